// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared constants and helpers for the Barrett modular multiplier pipe
// MM_LAZY_REDUCE_EN widens the result to N+1 bits and selects single-compare reduction.
package mm_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 54;
  localparam int DEFAULT_MULT_STAGES = 3;
  localparam int DEFAULT_TAG_WIDTH   = 4;

  function automatic int mm_latency(input int mult_stages);
    return 3 * mult_stages + 2;
  endfunction

  // Lazy results lie in [0,2q), which needs one extra bit because q[N-1] is set.
  function automatic int mm_out_width(input int data_width);
`ifdef MM_LAZY_REDUCE_EN
    return data_width + 1;
`else
    return data_width;
`endif
  endfunction

endpackage

// File: rtl/mm_barrett_pipe_if.sv
// rtl/mm_barrett_pipe_if.sv - operand/result stream bundle for mm_barrett_pipe
interface mm_barrett_pipe_if #(
  parameter int DATA_WIDTH = 54,
  parameter int TAG_WIDTH  = 4
);
  import mm_pkg::*;

  localparam int OUT_WIDTH = mm_out_width(DATA_WIDTH);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic [DATA_WIDTH-1:0] in_mod;
  logic [DATA_WIDTH:0]   in_mod_inv;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_WIDTH-1:0]  out_data;
  logic [TAG_WIDTH-1:0]  out_tag;

  modport master (
    output in_valid, in_a, in_b, in_mod, in_mod_inv, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mod, in_mod_inv, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/mm_pipe_mult.sv
// rtl/mm_pipe_mult.sv - unsigned multiplier followed by STAGES clock-enabled registers
// OUT_LSB/OUT_W select the slice of the product that the caller actually consumes.
module mm_pipe_mult #(
  parameter int AW      = 54,
  parameter int BW      = 54,
  parameter int STAGES  = 3,
  parameter int OUT_LSB = 0,
  parameter int OUT_W   = AW + BW
) (
  input  logic             clk,
  input  logic             ce_i,
  input  logic [AW-1:0]    a_i,
  input  logic [BW-1:0]    b_i,
  output logic [OUT_W-1:0] p_o
);

  logic [AW+BW-1:0] prod;
  logic [OUT_W-1:0] pipe_q [STAGES];

  always_comb prod = (AW+BW)'(a_i) * (AW+BW)'(b_i);

  // Retiming spreads the product across the register chain.
  always_ff @(posedge clk) begin
    if (ce_i) begin
      pipe_q[0] <= OUT_W'(prod >> OUT_LSB);
      for (int k = 1; k < STAGES; k++) begin
        pipe_q[k] <= pipe_q[k-1];
      end
    end
  end

  assign p_o = pipe_q[STAGES-1];

endmodule

// File: rtl/mm_barrett_pipe.sv
// rtl/mm_barrett_pipe.sv - stall-rigid Barrett (a*b) mod q pipe with per-op modulus and tag
// MM_LAZY_REDUCE_EN: final stage reduces only to [0,2q).
module mm_barrett_pipe
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int MULT_STAGES = DEFAULT_MULT_STAGES,
  parameter int TAG_WIDTH   = DEFAULT_TAG_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  mm_barrett_pipe_if.slave   mm
);

  localparam int N         = DATA_WIDTH;
  localparam int S         = MULT_STAGES;
  localparam int SB_DEPTH  = 3 * S;
  localparam int OUT_WIDTH = mm_out_width(N);

  typedef struct packed {
    logic [N-1:0]         q;
    logic [N:0]           mu;
    logic [N:0]           u_lo;
    logic [TAG_WIDTH-1:0] tag;
    logic                 valid;
  } sb_t;

  logic                 ce;
  sb_t                  sb_q [SB_DEPTH];
  sb_t                  sb_d [SB_DEPTH];
  logic [2*N-1:0]       u;
  logic [N:0]           w;
  logic [N:0]           x;
  logic [N:0]           z_d, z_q;
  logic [N-1:0]         zq_q;
  logic [TAG_WIDTH-1:0] ztag_q;
  logic                 zvld_q;
  logic [N+1:0]         z_ext, q1_ext, q2_ext, res;
  logic [OUT_WIDTH-1:0] out_data_d, out_data_q;
  logic [TAG_WIDTH-1:0] out_tag_q;
  logic                 out_valid_q;

  assign ce          = mm.out_ready | ~out_valid_q;
  assign mm.in_ready = ce;

  mm_pipe_mult #(.AW(N), .BW(N), .STAGES(S), .OUT_LSB(0), .OUT_W(2*N)) u_mult_ab (
    .clk (clk), .ce_i(ce), .a_i(mm.in_a), .b_i(mm.in_b), .p_o(u)
  );

  mm_pipe_mult #(.AW(N+1), .BW(N+1), .STAGES(S), .OUT_LSB(N+1), .OUT_W(N+1)) u_mult_vmu (
    .clk (clk), .ce_i(ce), .a_i(u[2*N-1:N-1]), .b_i(sb_q[S-1].mu), .p_o(w)
  );

  mm_pipe_mult #(.AW(N+1), .BW(N), .STAGES(S), .OUT_LSB(0), .OUT_W(N+1)) u_mult_wq (
    .clk (clk), .ce_i(ce), .a_i(w), .b_i(sb_q[2*S-1].q), .p_o(x)
  );

  // Sideband slot k lines up with register stage k of the multiplier chain.
  always_comb begin
    for (int k = 0; k < SB_DEPTH; k++) begin
      sb_d[k] = sb_q[k];
    end
    if (ce) begin
      sb_d[0] = '{q: mm.in_mod, mu: mm.in_mod_inv, u_lo: '0, tag: mm.in_tag, valid: mm.in_valid};
      for (int k = 1; k < SB_DEPTH; k++) begin
        sb_d[k] = sb_q[k-1];
      end
      sb_d[S].u_lo = u[N:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < SB_DEPTH; k++) begin
        sb_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SB_DEPTH; k++) begin
        sb_q[k] <= sb_d[k];
      end
    end
  end

  assign z_d = sb_q[SB_DEPTH-1].u_lo - x;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zvld_q <= 1'b0;
    end else if (ce) begin
      zvld_q <= sb_q[SB_DEPTH-1].valid;
    end
  end

  always_ff @(posedge clk) begin
    if (ce) begin
      z_q    <= z_d;
      zq_q   <= sb_q[SB_DEPTH-1].q;
      ztag_q <= sb_q[SB_DEPTH-1].tag;
    end
  end

  // z < 3q, so at most two subtractions of q bring it into range.
  always_comb begin
    z_ext  = {1'b0, z_q};
    q1_ext = {2'b00, zq_q};
    q2_ext = {1'b0, zq_q, 1'b0};
`ifdef MM_LAZY_REDUCE_EN
    res = (z_ext >= q2_ext) ? z_ext - q1_ext : z_ext;
`else
    if (z_ext >= q2_ext) begin
      res = z_ext - q2_ext;
    end else if (z_ext >= q1_ext) begin
      res = z_ext - q1_ext;
    end else begin
      res = z_ext;
    end
`endif
    out_data_d = OUT_WIDTH'(res);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else if (ce) begin
      out_valid_q <= zvld_q;
      out_data_q  <= out_data_d;
      out_tag_q   <= ztag_q;
    end
  end

  assign mm.out_valid = out_valid_q;
  assign mm.out_data  = out_data_q;
  assign mm.out_tag   = out_tag_q;

endmodule
